// File: rtl/replica_timing_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : replica_timing_monitor
//  Description : Launch/capture endpoint for the frontend critical-path
//                replica chain. It toggles a launch bit every cycle and checks
//                the (non-inverting) replica output at the following edge.
//                Errors are counted per window, and an alert req/ack handshake
//                is raised toward the recovery controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module replica_timing_monitor #(
    parameter int WARMUP_CYCLES  = 2,
    parameter int WINDOW         = 256,
    parameter int THRESHOLD      = 4,
    parameter int HOLDOFF_CYCLES = 16,
    parameter int CNT_W          = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             enable_i,
    input  logic             clr_i,
    output logic             launch_o,
    input  logic             replica_out_i,
    output logic             err_pulse_o,
    output logic [CNT_W-1:0] err_total_o,
    output logic             alert_req_o,
    input  logic             alert_ack_i,
    output logic [2:0]       state_o
);

    localparam int WU_W  = (WARMUP_CYCLES > 1)  ? $clog2(WARMUP_CYCLES)  : 1;
    localparam int WIN_W = (WINDOW > 1)         ? $clog2(WINDOW)         : 1;
    localparam int HO_W  = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam int ERR_W = $clog2(THRESHOLD + 1);

    localparam logic [WU_W-1:0]  c_WU_LAST  = WU_W'(WARMUP_CYCLES - 1);
    localparam logic [WIN_W-1:0] c_WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [HO_W-1:0]  c_HO_LAST  = HO_W'(HOLDOFF_CYCLES - 1);
    localparam logic [ERR_W-1:0] c_THRESH   = ERR_W'(THRESHOLD);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WARMUP  = 3'd1,
        S_MONITOR = 3'd2,
        S_ALERT   = 3'd3,
        S_HOLDOFF = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WU_W-1:0]    r_warm_cnt;
    logic [WU_W-1:0]    w_warm_nxt;
    logic [WIN_W-1:0]   r_win_cnt;
    logic [WIN_W-1:0]   w_win_cnt_nxt;
    logic [ERR_W-1:0]   r_win_err;
    logic [ERR_W-1:0]   w_win_err_nxt;
    logic [HO_W-1:0]    r_hold_cnt;
    logic [HO_W-1:0]    w_hold_nxt;

    logic               r_launch;
    logic               r_err_pulse;
    logic [CNT_W-1:0]   r_err_total;
    logic               r_alert_req;

    logic               w_compare;
    logic               w_mismatch;
    logic               w_win_wrap;
    logic [ERR_W-1:0]   w_win_err_sum;

    // Compare against the launch value that was presented before this edge;
    // a wrap edge's mismatch opens the new window's count.
    always_comb begin
        w_compare     = (r_state == S_MONITOR) || (r_state == S_ALERT) ||
                        (r_state == S_HOLDOFF);
        w_mismatch    = w_compare && (replica_out_i != r_launch);
        w_win_wrap    = (r_win_cnt == c_WIN_LAST);
        w_win_err_sum = w_win_wrap ? ERR_W'(w_mismatch)
                                   : (r_win_err + ERR_W'(w_mismatch));
    end

    // Next-state and counter logic; enable low overrides every transition.
    always_comb begin
        w_state_nxt   = r_state;
        w_warm_nxt    = r_warm_cnt;
        w_win_cnt_nxt = r_win_cnt;
        w_win_err_nxt = r_win_err;
        w_hold_nxt    = r_hold_cnt;
        if (!enable_i) begin
            w_state_nxt   = S_IDLE;
            w_warm_nxt    = '0;
            w_win_cnt_nxt = '0;
            w_win_err_nxt = '0;
            w_hold_nxt    = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_WARMUP;
                    w_warm_nxt  = '0;
                end
                S_WARMUP: begin
                    if (r_warm_cnt == c_WU_LAST) begin
                        w_state_nxt   = S_MONITOR;
                        w_warm_nxt    = '0;
                        w_win_cnt_nxt = '0;
                        w_win_err_nxt = '0;
                    end else begin
                        w_warm_nxt = r_warm_cnt + WU_W'(1);
                    end
                end
                S_MONITOR: begin
                    if (w_win_err_sum >= c_THRESH) begin
                        w_state_nxt   = S_ALERT;
                        w_win_cnt_nxt = '0;
                        w_win_err_nxt = '0;
                    end else begin
                        w_win_cnt_nxt = w_win_wrap ? '0 : (r_win_cnt + WIN_W'(1));
                        w_win_err_nxt = w_win_err_sum;
                    end
                end
                S_ALERT: begin
                    if (alert_ack_i) begin
                        w_state_nxt = S_HOLDOFF;
                        w_hold_nxt  = '0;
                    end
                end
                S_HOLDOFF: begin
                    if (r_hold_cnt == c_HO_LAST) begin
                        w_state_nxt   = S_MONITOR;
                        w_hold_nxt    = '0;
                        w_win_cnt_nxt = '0;
                        w_win_err_nxt = '0;
                    end else begin
                        w_hold_nxt = r_hold_cnt + HO_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // State register and phase counters.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state    <= S_IDLE;
            r_warm_cnt <= '0;
            r_win_cnt  <= '0;
            r_win_err  <= '0;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_warm_cnt <= w_warm_nxt;
            r_win_cnt  <= w_win_cnt_nxt;
            r_win_err  <= w_win_err_nxt;
            r_hold_cnt <= w_hold_nxt;
        end
    end

    // Registered outputs: launch toggle, error pulse/total, alert request.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_launch    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_total <= '0;
            r_alert_req <= 1'b0;
        end else begin
            r_launch    <= (w_state_nxt == S_IDLE) ? 1'b0 : ~r_launch;
            r_err_pulse <= w_mismatch;
            r_alert_req <= (w_state_nxt == S_ALERT);
            if (clr_i) begin
                r_err_total <= '0;
            end else if (w_mismatch && (r_err_total != '1)) begin
                r_err_total <= r_err_total + CNT_W'(1);
            end
        end
    end

    assign launch_o    = r_launch;
    assign err_pulse_o = r_err_pulse;
    assign err_total_o = r_err_total;
    assign alert_req_o = r_alert_req;
    assign state_o     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_replica_timing_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_replica_timing_monitor
//  Description : Directed bench for replica_timing_monitor. Stimulus queues
//                cycle-tagged expected values; a negedge monitor compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_replica_timing_monitor;

    localparam int SIG_STATE  = 0;
    localparam int SIG_LAUNCH = 1;
    localparam int SIG_PULSE  = 2;
    localparam int SIG_TOTAL  = 3;
    localparam int SIG_ALERT  = 4;
    localparam int SIG_TSAT   = 5;
    localparam int SIG_SSAT   = 6;
    localparam int SIG_PSAT   = 7;
    localparam int SIG_ASAT   = 8;
    localparam int SIG_LSAT   = 9;

    typedef struct {
        int    cyc;
        int    sig;
        int    val;
        string name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        clr;
    logic        ack;
    logic        inj;
    logic        enable2;
    logic        launch;
    logic        replica;
    logic        pulse;
    logic [15:0] total;
    logic        alert;
    logic [2:0]  state;
    logic        launch2;
    logic        replica2;
    logic        pulse2;
    logic [3:0]  total2;
    logic        alert2;
    logic [2:0]  state2;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    // Replica models: main chain carries an injectable fault, second is always broken.
    assign replica  = launch ^ inj;
    assign replica2 = ~launch2;

    replica_timing_monitor #(
        .WARMUP_CYCLES(2), .WINDOW(256), .THRESHOLD(4), .HOLDOFF_CYCLES(16), .CNT_W(16)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .clr_i(clr),
        .launch_o(launch), .replica_out_i(replica), .err_pulse_o(pulse),
        .err_total_o(total), .alert_req_o(alert), .alert_ack_i(ack),
        .state_o(state)
    );

    replica_timing_monitor #(
        .WARMUP_CYCLES(2), .WINDOW(256), .THRESHOLD(4), .HOLDOFF_CYCLES(16), .CNT_W(4)
    ) dut_sat (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable2), .clr_i(clr),
        .launch_o(launch2), .replica_out_i(replica2), .err_pulse_o(pulse2),
        .err_total_o(total2), .alert_req_o(alert2), .alert_ack_i(1'b1),
        .state_o(state2)
    );

    always #5 clk = ~clk;

    // Edge counter: value N after the Nth rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int actual(int sig);
        case (sig)
            SIG_STATE:  return int'(state);
            SIG_LAUNCH: return int'(launch);
            SIG_PULSE:  return int'(pulse);
            SIG_TOTAL:  return int'(total);
            SIG_ALERT:  return int'(alert);
            SIG_TSAT:   return int'(total2);
            SIG_SSAT:   return int'(state2);
            SIG_PSAT:   return int'(pulse2);
            SIG_ASAT:   return int'(alert2);
            SIG_LSAT:   return int'(launch2);
            default:    return -1;
        endcase
    endfunction

    task automatic chk_at(int c, int sig, int val, string name);
        exp_t e;
        e.cyc  = c;
        e.sig  = sig;
        e.val  = val;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(int target);
        while (cyc < target) step();
    endtask

    // One-cycle replica fault sampled at edge e.
    task automatic inject(int e);
        run_to(e - 1);
        inj = 1'b1;
        step();
        inj = 1'b0;
        chk_at(cyc, SIG_PULSE, 1, "inj_pulse");
    endtask

    // Monitor: compare every expectation due at this edge count.
    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc <= cyc) begin
                checks++;
                if (q[i].cyc < cyc) begin
                    errors++;
                    $display("FAIL %s: missed check at cycle %0d (now %0d)", q[i].name, q[i].cyc, cyc);
                end else if (actual(q[i].sig) != q[i].val) begin
                    errors++;
                    $display("FAIL %s @cycle %0d: got %0d, expected %0d",
                             q[i].name, cyc, actual(q[i].sig), q[i].val);
                end
                q.delete(i);
            end
        end
    end

    initial begin
        int b;
        rst_n = 1'b0; enable = 1'b0; clr = 1'b0; ack = 1'b0; inj = 1'b0; enable2 = 1'b0;
        step(); step();
        chk_at(cyc, SIG_STATE,  0, "rst_state");
        chk_at(cyc, SIG_LAUNCH, 0, "rst_launch");
        chk_at(cyc, SIG_PULSE,  0, "rst_pulse");
        chk_at(cyc, SIG_TOTAL,  0, "rst_total");
        chk_at(cyc, SIG_ALERT,  0, "rst_alert");

        // Healthy replica: warmup of two cycles, then clean monitoring.
        rst_n = 1'b1; enable = 1'b1;
        b = cyc;
        chk_at(b + 1, SIG_STATE, 1, "wu_state1");
        chk_at(b + 1, SIG_LAUNCH, 1, "wu_launch1");
        chk_at(b + 2, SIG_STATE, 1, "wu_state2");
        chk_at(b + 2, SIG_LAUNCH, 0, "wu_launch2");
        chk_at(b + 3, SIG_STATE, 2, "mon_state");
        chk_at(b + 3, SIG_LAUNCH, 1, "mon_launch");
        for (int k = 0; k < 1000; k++) begin
            step();
            chk_at(cyc, SIG_PULSE, 0, "clean_pulse");
        end
        chk_at(cyc, SIG_TOTAL, 0, "clean_total");
        chk_at(cyc, SIG_STATE, 2, "clean_state");
        chk_at(cyc, SIG_LAUNCH, 0, "clean_launch");

        // Inverted replica from enable: first monitor compare errs, 4th alerts.
        enable = 1'b0;
        step();
        b = cyc;
        chk_at(b, SIG_STATE, 0, "dis_state");
        chk_at(b, SIG_LAUNCH, 0, "dis_launch");
        inj = 1'b1; enable = 1'b1;
        chk_at(b + 1, SIG_PULSE, 0, "wu_nopulse1");
        chk_at(b + 2, SIG_PULSE, 0, "wu_nopulse2");
        chk_at(b + 3, SIG_PULSE, 0, "wu_nopulse3");
        chk_at(b + 4, SIG_PULSE, 1, "first_err_pulse");
        chk_at(b + 4, SIG_TOTAL, 1, "first_err_total");
        chk_at(b + 6, SIG_STATE, 2, "pre_alert_state");
        chk_at(b + 6, SIG_ALERT, 0, "pre_alert_req");
        chk_at(b + 7, SIG_STATE, 3, "alert_state");
        chk_at(b + 7, SIG_ALERT, 1, "alert_req");
        chk_at(b + 7, SIG_TOTAL, 4, "alert_total");
        run_to(b + 7);

        // Handshake: request holds without ack, then holdoff of 16 cycles.
        for (int k = 0; k < 10; k++) begin
            step();
            chk_at(cyc, SIG_ALERT, 1, "hold_req");
            chk_at(cyc, SIG_STATE, 3, "hold_state");
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        b = cyc;
        chk_at(b, SIG_ALERT, 0, "ack_req");
        chk_at(b, SIG_STATE, 4, "ack_state");
        chk_at(b + 15, SIG_STATE, 4, "holdoff_end");
        chk_at(b + 16, SIG_STATE, 2, "holdoff_exit");
        chk_at(b + 16, SIG_TOTAL, 31, "holdoff_total");
        run_to(b + 16);

        // Window wrap: 3 errors ending window 1, 3 starting window 2 at the
        // wrap edge, then a 4th in window 2 alerts.
        enable = 1'b0; inj = 1'b0;
        step();
        b = cyc;
        enable = 1'b1;
        chk_at(b + 3, SIG_STATE, 2, "win_mon");
        for (int k = 256; k <= 261; k++) inject(b + k);
        chk_at(cyc, SIG_STATE, 2, "wrap_no_alert");
        run_to(b + 299);
        chk_at(cyc, SIG_STATE, 2, "win2_state");
        chk_at(cyc, SIG_ALERT, 0, "win2_req");
        inject(b + 300);
        chk_at(cyc, SIG_STATE, 3, "win2_alert_state");
        chk_at(cyc, SIG_ALERT, 1, "win2_alert_req");
        chk_at(cyc, SIG_TOTAL, 38, "win2_total");

        // Enable drop in ALERT beats a simultaneous acknowledge.
        enable = 1'b0; ack = 1'b1;
        step();
        ack = 1'b0;
        chk_at(cyc, SIG_STATE, 0, "abort_state");
        chk_at(cyc, SIG_ALERT, 0, "abort_req");
        chk_at(cyc, SIG_LAUNCH, 0, "abort_launch");

        // Clear wins over a simultaneous mismatch.
        enable = 1'b1;
        run_to(cyc + 3);
        chk_at(cyc, SIG_STATE, 2, "reen_state");
        inj = 1'b1; clr = 1'b1;
        step();
        clr = 1'b0;
        chk_at(cyc, SIG_PULSE, 1, "clr_pulse");
        chk_at(cyc, SIG_TOTAL, 0, "clr_total");
        step();
        chk_at(cyc, SIG_TOTAL, 1, "post_clr_total");

        // Reset in MONITOR with a pending mismatch.
        rst_n = 1'b0;
        step();
        chk_at(cyc, SIG_STATE, 0, "mrst_state");
        chk_at(cyc, SIG_LAUNCH, 0, "mrst_launch");
        chk_at(cyc, SIG_PULSE, 0, "mrst_pulse");
        chk_at(cyc, SIG_TOTAL, 0, "mrst_total");
        chk_at(cyc, SIG_ALERT, 0, "mrst_alert");

        // 4-bit counter saturation with continuous errors and ack tied high.
        rst_n = 1'b1; inj = 1'b0; enable = 1'b0; enable2 = 1'b1;
        b = cyc;
        chk_at(b + 1, SIG_SSAT, 1, "sat_warmup");
        chk_at(b + 1, SIG_LSAT, 1, "sat_launch");
        chk_at(b + 4, SIG_PSAT, 1, "sat_first_pulse");
        chk_at(b + 7, SIG_ASAT, 1, "sat_alert");
        chk_at(b + 17, SIG_TSAT, 14, "sat_total14");
        chk_at(b + 18, SIG_TSAT, 15, "sat_total15");
        chk_at(b + 40, SIG_TSAT, 15, "sat_stuck");
        run_to(b + 40);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk_at(cyc, SIG_TSAT, 0, "sat_clr");
        step();
        chk_at(cyc, SIG_TSAT, 1, "sat_after_clr");

        for (int k = 0; k < 5 && q.size() > 0; k++) step();
        while (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s: check for cycle %0d never evaluated", q[0].name, q[0].cyc);
            q.delete(0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
